// File: rtl/key_pkg.sv
// Shared definitions for the decimal key debouncer: key count, default
// debounce length, FSM state type and one-hot / multi-hot helpers.
package key_pkg;

    localparam int unsigned NUM_KEYS      = 10;
    localparam int unsigned DB_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_OUT      = 2'd2,
        ST_WAIT_REL = 2'd3
    } key_state_e;

    // Exactly one bit set
    function automatic logic is_one_hot(input logic [NUM_KEYS-1:0] v);
        return (v != '0) && ((v & (v - NUM_KEYS'(1))) == '0);
    endfunction

    // Two or more bits set
    function automatic logic is_multi_hot(input logic [NUM_KEYS-1:0] v);
        return (v & (v - NUM_KEYS'(1))) != '0;
    endfunction

endpackage

// File: rtl/key_sync2.sv
// Two-flop synchronizer, one chain per bit.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronized).
module key_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/key_dec_debounce.sv
// Debounces ten decimal key lines and hands one accepted key per press to
// the downstream BCD encoder over a valid/ready handshake.
// Ports: clk, rst_n (async active-low), key_raw[9:0] (async keys),
//        ready (downstream accept), y[9:0] (one-hot key, 0 when !valid),
//        valid (y holds a key), err (more than one key down while idle).
module key_dec_debounce
    import key_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_raw,
    input  logic                ready,
    output logic [NUM_KEYS-1:0] y,
    output logic                valid,
    output logic                err
);

    localparam int unsigned  CNT_W   = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [NUM_KEYS-1:0] ks;

    key_state_e          state_d, state_q;
    logic [CNT_W-1:0]    cnt_d,   cnt_q;
    logic [NUM_KEYS-1:0] cand_d,  cand_q;
    logic [NUM_KEYS-1:0] y_d,     y_q;
    logic                valid_d, valid_q;
    logic                err_d,   err_q;

    key_sync2 #(.WIDTH(NUM_KEYS)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (key_raw),
        .q     (ks)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        y_d     = y_q;
        valid_d = valid_q;
        err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                err_d = is_multi_hot(ks);
                if (is_one_hot(ks)) begin
                    cand_d  = ks;
                    cnt_d   = '0;
                    state_d = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (ks != cand_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_OUT;
                    y_d     = cand_q;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_OUT: begin
                // Output frozen until the single handshake; ks is ignored here
                if (valid_q && ready) begin
                    y_d     = '0;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_WAIT_REL;
                end
            end
            ST_WAIT_REL: begin
                // Any key activity restarts the release window
                if (ks != '0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign y     = y_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: tb/tb_key_dec_debounce.sv
// Scoreboard bench for key_dec_debounce with DB_CYCLES=4: directed cases
// followed by randomized press / bounce / multi-key episodes.
module tb_key_dec_debounce;

    localparam int unsigned DB = 4;
    localparam int unsigned NK = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] key_raw;
    logic          ready;
    logic [NK-1:0] y;
    logic          valid;
    logic          err;

    int checks   = 0;
    int failures = 0;

    logic [NK-1:0] exp_q[$];

    always #5 clk = ~clk;

    key_dec_debounce #(.DB_CYCLES(DB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_raw (key_raw),
        .ready   (ready),
        .y       (y),
        .valid   (valid),
        .err     (err)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Monitor: every handshake must match the oldest expected key
    logic          prev_hold = 1'b0;
    logic [NK-1:0] prev_y    = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 32'(valid), 32'd1);
                check("hold_y", 32'(y), 32'(prev_y));
            end
            if (!valid) check("y_zero_when_idle", 32'(y), 32'd0);
            if (valid && ready) begin
                if (exp_q.size() == 0) check("transfer_expected", 32'(exp_q.size()), 32'd1);
                else check("transfer_y", 32'(y), 32'(exp_q.pop_front()));
            end
            prev_hold = valid && !ready;
            prev_y    = y;
        end
    end

    // One clock edge, then settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        key_raw = '0;
        ready   = 1'b1;
        for (int j = 0; j < n; j++) begin
            step();
            if (j >= 3) check("gap_err", 32'(err), 32'd0);
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (!valid && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(valid), 32'd1);
    endtask

    function automatic logic [NK-1:0] rand_one_hot();
        logic [NK-1:0] v;
        v = NK'(1) << $urandom_range(0, NK - 1);
        return v;
    endfunction

    function automatic logic [NK-1:0] rand_multi_hot();
        int unsigned a, b;
        logic [NK-1:0] v;
        a = $urandom_range(0, NK - 1);
        b = (a + $urandom_range(1, NK - 1)) % NK;
        v = (NK'(1) << a) | (NK'(1) << b) | (NK'($urandom) & NK'($urandom));
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NK-1:0] k;
        int            len;
        int            kind;

        rst_n   = 1'b0;
        key_raw = '0;
        ready   = 1'b0;
        step(); step(); step();
        check("rst_y", 32'(y), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        gap(4);

        // Clean press, ready high: valid for exactly one cycle, no repeat
        key_raw = 10'h008;
        ready   = 1'b1;
        exp_q.push_back(10'h008);
        for (int i = 0; i < 14; i++) begin
            step();
            if (i == 5) check("lat_valid_before", 32'(valid), 32'd0);
            if (i == 6) begin
                check("lat_valid_at", 32'(valid), 32'd1);
                check("lat_y_at", 32'(y), 32'h008);
            end
            if (i >= 7) check("held_no_repeat", 32'(valid), 32'd0);
        end
        gap(DB + 8);

        // Backpressure: ten cycles of ready low, one transfer, then WAIT_REL
        key_raw = 10'h200;
        ready   = 1'b0;
        exp_q.push_back(10'h200);
        wait_valid("bp_valid_rise", 20);
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_valid_stable", 32'(valid), 32'd1);
            check("bp_y_stable", 32'(y), 32'h200);
        end
        ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("bp_after_transfer", 32'(valid), 32'd0);
        end
        gap(DB + 8);

        // Short bounce: never accepted
        key_raw = 10'h002;
        ready   = 1'b1;
        for (int i = 0; i < 3; i++) step();
        key_raw = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            check("bounce_no_valid", 32'(valid), 32'd0);
        end

        // Two keys down: err while idle, clears after release reaches ks
        key_raw = 10'h011;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) check("multi_err_early", 32'(err), 32'd0);
            if (i >= 3) begin
                check("multi_err", 32'(err), 32'd1);
                check("multi_valid", 32'(valid), 32'd0);
            end
        end
        key_raw = '0;
        for (int j = 0; j < 4; j++) begin
            step();
            if (j == 1) check("multi_err_lag", 32'(err), 32'd1);
            if (j >= 2) check("multi_err_clear", 32'(err), 32'd0);
        end
        gap(DB + 4);

        // Release bounce during WAIT_REL, then a different key
        key_raw = 10'h008;
        ready   = 1'b1;
        exp_q.push_back(10'h008);
        for (int i = 0; i < 10; i++) step();
        for (int r = 0; r < 4; r++) begin
            key_raw = '0;
            step(); step();
            key_raw = 10'h008;
            step(); step();
            check("relbounce_no_valid", 32'(valid), 32'd0);
        end
        key_raw = '0;
        for (int i = 0; i < 6; i++) step();
        key_raw = 10'h020;
        exp_q.push_back(10'h020);
        for (int i = 0; i < 10; i++) step();
        gap(DB + 8);

        // Async reset while valid: drop at once, re-debounce the held key
        key_raw = 10'h040;
        ready   = 1'b0;
        exp_q.push_back(10'h040);
        wait_valid("rstout_valid_rise", 20);
        rst_n = 1'b0;
        #1;
        check("rstout_valid_drop", 32'(valid), 32'd0);
        check("rstout_y_drop", 32'(y), 32'd0);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        step(); step();
        rst_n = 1'b1;
        exp_q.push_back(10'h040);
        for (int i = 0; i < 7; i++) begin
            step();
            if (i == 5) check("rstout_valid_before", 32'(valid), 32'd0);
            if (i == 6) begin
                check("rstout_valid_at", 32'(valid), 32'd1);
                check("rstout_y_at", 32'(y), 32'h040);
            end
        end
        gap(DB + 8);

        // Random episodes; gaps are long enough to return to IDLE
        for (int e = 0; e < 40; e++) begin
            kind = int'($urandom_range(0, 2));
            if (kind == 0) begin
                len = int'($urandom_range(DB + 1, 25));
                k   = rand_one_hot();
                exp_q.push_back(k);
            end else if (kind == 1) begin
                len = int'($urandom_range(1, DB));
                k   = rand_one_hot();
            end else begin
                len = int'($urandom_range(4, 15));
                k   = rand_multi_hot();
            end
            key_raw = k;
            ready   = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                step();
                if (kind == 0 && len > int'(DB) + 2) begin
                    if (i == int'(DB) + 1) check("rnd_lat_before", 32'(valid), 32'd0);
                    if (i == int'(DB) + 2) check("rnd_lat_at", 32'(valid), 32'd1);
                end
                if (kind == 0) check("rnd_press_err", 32'(err), 32'd0);
                if (kind == 1) check("rnd_bounce_valid", 32'(valid), 32'd0);
                if (kind == 2) begin
                    check("rnd_multi_valid", 32'(valid), 32'd0);
                    if (i == 0) check("rnd_multi_err_early", 32'(err), 32'd0);
                    if (i >= 3) check("rnd_multi_err", 32'(err), 32'd1);
                end
                ready = 1'($urandom_range(0, 1));
            end
            gap(int'(DB) + 8 + int'($urandom_range(0, 4)));
        end

        gap(DB + 8);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
